// File: rtl/gray_to_rgb.sv
// Gray-to-RGB pixel stage between an 8-bit gray FIFO and a 24-bit RGB FIFO.
// Each pixel is fetched, colored (border mask / highlight / gray), then emitted.
module gray_to_rgb #(
    parameter int          WIDTH     = 720,
    parameter int          HEIGHT    = 540,
    parameter logic [7:0]  THRESH    = 8'hFF,
    parameter logic [23:0] HIGHLIGHT = 24'hFF0000,
    parameter int          BORDER    = 1
) (
    input  logic        clock,
    input  logic        reset,
    output logic        in_rd_en,
    input  logic        in_empty,
    input  logic [7:0]  in_dout,
    output logic        out_wr_en,
    input  logic        out_full,
    output logic [23:0] out_din,
    output logic        frame_done
);
    localparam int XW = $clog2(WIDTH);
    localparam int YW = $clog2(HEIGHT);
    localparam logic [XW-1:0] X_LAST = XW'(WIDTH - 1);
    localparam logic [YW-1:0] Y_LAST = YW'(HEIGHT - 1);

    // One-hot encoding so the two unused codes are detectably illegal.
    typedef enum logic [1:0] {
        FETCH = 2'b01,
        EMIT  = 2'b10
    } state_t;

    state_t         state_q, state_d;
    logic [XW-1:0]  x_q, x_d;
    logic [YW-1:0]  y_q, y_d;
    logic [23:0]    pix_q, pix_d;
    logic           on_edge;
    logic [23:0]    color;

    // Color is decided at fetch time against the position the pixel will occupy.
    always_comb begin
        on_edge = (BORDER != 0) &&
                  (x_q == '0 || x_q == X_LAST || y_q == '0 || y_q == Y_LAST);
        if (on_edge)
            color = 24'h000000;
        else if (in_dout >= THRESH)
            color = HIGHLIGHT;
        else
            color = {in_dout, in_dout, in_dout};
    end

    always_comb begin
        state_d    = state_q;
        x_d        = x_q;
        y_d        = y_q;
        pix_d      = pix_q;
        in_rd_en   = 1'b0;
        out_wr_en  = 1'b0;
        out_din    = 24'h0;
        frame_done = 1'b0;
        case (state_q)
            FETCH: begin
                if (!in_empty) begin
                    in_rd_en = 1'b1;
                    pix_d    = color;
                    state_d  = EMIT;
                end
            end
            EMIT: begin
                if (!out_full) begin
                    out_wr_en = 1'b1;
                    out_din   = pix_q;
                    state_d   = FETCH;
                    if (x_q == X_LAST) begin
                        x_d = '0;
                        if (y_q == Y_LAST) begin
                            y_d        = '0;
                            frame_done = 1'b1;
                        end else begin
                            y_d = y_q + 1'b1;
                        end
                    end else begin
                        x_d = x_q + 1'b1;
                    end
                end
            end
            default: state_d = FETCH;
        endcase
        // Handshakes stay quiet for the whole reset window, not just after the edge.
        if (reset) begin
            in_rd_en   = 1'b0;
            out_wr_en  = 1'b0;
            out_din    = 24'h0;
            frame_done = 1'b0;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= FETCH;
            x_q     <= '0;
            y_q     <= '0;
            pix_q   <= 24'h0;
        end else begin
            state_q <= state_d;
            x_q     <= x_d;
            y_q     <= y_d;
            pix_q   <= pix_d;
        end
    end
endmodule

// File: tb/tb_gray_to_rgb.sv
// Bench for gray_to_rgb: two 4x4 instances (no border / border), FIFO models
// driven per cycle and a scoreboard of expected {frame_done, rgb} per write.
module tb_gray_to_rgb;
    logic clock = 1'b0;
    always #5 clock = ~clock;

    logic        reset;
    logic [1:0]  in_empty, out_full, rd_w, wr_w, fd_w;
    logic [7:0]  in_dout [2];
    logic [23:0] din_w [2];

    gray_to_rgb #(.WIDTH(4), .HEIGHT(4), .THRESH(8'h80), .HIGHLIGHT(24'hFF0000), .BORDER(0)) dut0 (
        .clock(clock), .reset(reset), .in_rd_en(rd_w[0]), .in_empty(in_empty[0]),
        .in_dout(in_dout[0]), .out_wr_en(wr_w[0]), .out_full(out_full[0]),
        .out_din(din_w[0]), .frame_done(fd_w[0]));

    gray_to_rgb #(.WIDTH(4), .HEIGHT(4), .THRESH(8'hFF), .HIGHLIGHT(24'h00FF00), .BORDER(1)) dut1 (
        .clock(clock), .reset(reset), .in_rd_en(rd_w[1]), .in_empty(in_empty[1]),
        .in_dout(in_dout[1]), .out_wr_en(wr_w[1]), .out_full(out_full[1]),
        .out_din(din_w[1]), .frame_done(fd_w[1]));

    int          tests = 0;
    int          fails = 0;
    logic [7:0]  src_q [2][$];
    logic [24:0] exp_q [2][$];
    int          pos [2];
    logic        full [2];
    logic        last_rd [2];
    logic        last_wr [2];
    logic [23:0] last_din [2];
    int          fd_cnt [2];

    function automatic logic [24:0] model(int d, logic [7:0] g, int p);
        int x = p % 4;
        int y = p / 4;
        logic [23:0] c;
        logic [7:0]  th = (d == 0) ? 8'h80 : 8'hFF;
        if (d == 1 && (x == 0 || x == 3 || y == 0 || y == 3)) c = 24'h000000;
        else if (g >= th) c = (d == 0) ? 24'hFF0000 : 24'h00FF00;
        else c = {g, g, g};
        return {(p == 15), c};
    endfunction

    task automatic push(int d, logic [7:0] g);
        src_q[d].push_back(g);
        exp_q[d].push_back(model(d, g, pos[d]));
        pos[d] = (pos[d] + 1) % 16;
    endtask

    task automatic clear_model();
        for (int d = 0; d < 2; d++) begin
            src_q[d].delete();
            exp_q[d].delete();
            pos[d] = 0;
        end
    endtask

    // One clock: present FIFO state at negedge, sample settled outputs, score writes.
    task automatic step();
        logic [24:0] e;
        logic [7:0]  g;
        @(negedge clock);
        for (int d = 0; d < 2; d++) begin
            in_empty[d] = (src_q[d].size() == 0);
            in_dout[d]  = (src_q[d].size() == 0) ? 8'h00 : src_q[d][0];
            out_full[d] = full[d];
        end
        #1;
        for (int d = 0; d < 2; d++) begin
            last_rd[d]  = rd_w[d];
            last_wr[d]  = wr_w[d];
            last_din[d] = din_w[d];
            tests++;
            if ((rd_w[d] && wr_w[d]) || (!wr_w[d] && (din_w[d] !== 24'h0 || fd_w[d] !== 1'b0))) begin
                fails++;
                $display("FAIL invariant dut%0d: rd=%b wr=%b din=%h fd=%b, required no rd&wr, din=0/fd=0 without wr",
                         d, rd_w[d], wr_w[d], din_w[d], fd_w[d]);
            end
            if (fd_w[d] === 1'b1) fd_cnt[d]++;
            if (wr_w[d] === 1'b1) begin
                tests++;
                if (exp_q[d].size() == 0) begin
                    fails++;
                    $display("FAIL unexpected_write dut%0d: din=%h, required no write", d, din_w[d]);
                end else begin
                    e = exp_q[d].pop_front();
                    if ({fd_w[d], din_w[d]} !== e) begin
                        fails++;
                        $display("FAIL scoreboard dut%0d: got fd=%b din=%h, required fd=%b din=%h",
                                 d, fd_w[d], din_w[d], e[24], e[23:0]);
                    end
                end
            end
            if (rd_w[d] === 1'b1 && src_q[d].size() > 0) g = src_q[d].pop_front();
        end
    endtask

    task automatic drain(int d, int max_cycles);
        int n = 0;
        while (exp_q[d].size() > 0 && n < max_cycles) begin
            step();
            n++;
        end
        tests++;
        if (exp_q[d].size() != 0) begin
            fails++;
            $display("FAIL drain_timeout dut%0d: %0d writes outstanding, required 0", d, exp_q[d].size());
        end
    endtask

    task automatic check_quiet(string name);
        for (int d = 0; d < 2; d++) begin
            tests++;
            if (rd_w[d] !== 1'b0 || wr_w[d] !== 1'b0 || fd_w[d] !== 1'b0 || din_w[d] !== 24'h0) begin
                fails++;
                $display("FAIL %s dut%0d: rd=%b wr=%b fd=%b din=%h, required all 0",
                         name, d, rd_w[d], wr_w[d], fd_w[d], din_w[d]);
            end
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        clear_model();
        repeat (3) begin
            step();
            check_quiet("reset_outputs");
        end
        reset = 1'b0;
        repeat (20) begin
            step();
            check_quiet("idle_empty");
        end
    endtask

    task automatic test_basic();
        push(0, 8'h40);
        step();
        tests++;
        if (last_rd[0] !== 1'b1 || last_wr[0] !== 1'b0) begin
            fails++;
            $display("FAIL basic_fetch: rd=%b wr=%b, required rd=1 wr=0", last_rd[0], last_wr[0]);
        end
        step();
        tests++;
        if (last_rd[0] !== 1'b0 || last_wr[0] !== 1'b1 || last_din[0] !== 24'h404040) begin
            fails++;
            $display("FAIL basic_emit: rd=%b wr=%b din=%h, required rd=0 wr=1 din=404040",
                     last_rd[0], last_wr[0], last_din[0]);
        end
    endtask

    task automatic test_thresh();
        push(0, 8'h80);
        push(0, 8'h7F);
        push(0, 8'h81);
        push(0, 8'hFF);
        push(0, 8'h00);
        drain(0, 40);
    endtask

    task automatic test_frame();
        fd_cnt[1] = 0;
        for (int i = 0; i < 17; i++) push(1, 8'h55);
        drain(1, 100);
        tests++;
        if (fd_cnt[1] !== 1) begin
            fails++;
            $display("FAIL frame_done_count: got %0d pulses, required 1", fd_cnt[1]);
        end
    endtask

    task automatic test_backpressure();
        push(0, 8'h21);
        push(0, 8'h22);
        full[0] = 1'b1;
        step();
        repeat (5) begin
            step();
            tests++;
            if (last_rd[0] !== 1'b0 || last_wr[0] !== 1'b0) begin
                fails++;
                $display("FAIL backpressure_hold: rd=%b wr=%b, required rd=0 wr=0", last_rd[0], last_wr[0]);
            end
        end
        full[0] = 1'b0;
        step();
        tests++;
        if (last_wr[0] !== 1'b1 || last_din[0] !== 24'h212121) begin
            fails++;
            $display("FAIL backpressure_release: wr=%b din=%h, required wr=1 din=212121", last_wr[0], last_din[0]);
        end
        drain(0, 20);
    endtask

    task automatic test_back_to_back();
        int n = 0;
        for (int i = 0; i < 32; i++) begin
            push(0, 8'($urandom_range(0, 255)));
            push(1, (i % 5 == 0) ? 8'hFF : 8'($urandom_range(0, 255)));
        end
        while ((exp_q[0].size() > 0 || exp_q[1].size() > 0) && n < 300) begin
            step();
            n++;
        end
        tests++;
        if (n != 64) begin
            fails++;
            $display("FAIL throughput: 32 pixels took %0d cycles, required 64", n);
        end
    endtask

    task automatic test_reset_mid();
        for (int i = 0; i < 5; i++) push(1, 8'h55);
        drain(1, 20);
        full[1] = 1'b1;
        push(1, 8'h99);
        step();
        step();
        @(negedge clock);
        full[1]     = 1'b0;
        out_full[1] = 1'b0;
        reset       = 1'b1;
        #1;
        check_quiet("async_reset");
        clear_model();
        push(1, 8'h55);
        push(1, 8'h77);
        repeat (2) begin
            step();
            tests++;
            if (last_rd[1] !== 1'b0) begin
                fails++;
                $display("FAIL reset_rd_gate: rd=%b, required 0", last_rd[1]);
            end
        end
        reset = 1'b0;
        drain(1, 20);
    endtask

    initial begin
        reset    = 1'b1;
        in_empty = 2'b11;
        out_full = 2'b00;
        in_dout[0] = 8'h00;
        in_dout[1] = 8'h00;
        full[0] = 1'b0;
        full[1] = 1'b0;
        fd_cnt[0] = 0;
        fd_cnt[1] = 0;
        test_reset();
        test_basic();
        test_thresh();
        test_frame();
        test_backpressure();
        test_back_to_back();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
